// File: rtl/approx_adder_error_monitor.sv
`default_nettype none
// ============================================================================
// Module   : approx_adder_error_monitor
// Brief    : Windowed error-distance statistics for an N-bit approximate adder.
// Revision : 1.0 - initial release
// ============================================================================
module approx_adder_error_monitor #(
    parameter int N           = 16,
    parameter int WINDOW_LOG2 = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [N-1:0]             a,
    input  logic [N-1:0]             b,
    input  logic [N:0]               approx_sum,
    output logic                     busy,
    output logic                     done,
    output logic [WINDOW_LOG2:0]     err_count,
    output logic [N+1+WINDOW_LOG2:0] sum_ed,
    output logic [N+WINDOW_LOG2:0]   sum_abs_ed,
    output logic [N:0]               max_abs_ed
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_accum = 2'd1;
    localparam logic [1:0] c_st_flush = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    localparam logic [WINDOW_LOG2:0] c_last_idx = {1'b0, {WINDOW_LOG2{1'b1}}};
    localparam logic [WINDOW_LOG2:0] c_cnt_one  = {{WINDOW_LOG2{1'b0}}, 1'b1};

    logic [1:0]               r_state;
    logic                     r_busy;
    logic                     r_done;
    logic [WINDOW_LOG2:0]     r_cnt;

    logic                     r_v;
    logic                     r_nz;
    logic [N+1:0]             r_ed;
    logic [N:0]               r_abs;

    logic [WINDOW_LOG2:0]     r_err_count;
    logic [N+1+WINDOW_LOG2:0] r_sum_ed;
    logic [N+WINDOW_LOG2:0]   r_sum_abs;
    logic [N:0]               r_max_abs;

    logic                     w_accept;
    logic                     w_clear;
    logic [N:0]               w_exact;
    logic [N+1:0]             w_ed;
    logic [N+1:0]             w_ed_neg;
    logic [N:0]               w_abs;

    assign w_accept = (r_state == c_st_accum) && in_valid;
    assign w_clear  = (r_state == c_st_idle) && start;

    // One extra bit beyond the exact sum keeps ED signed without overflow.
    assign w_exact  = {1'b0, a} + {1'b0, b};
    assign w_ed     = {1'b0, w_exact} - {1'b0, approx_sum};
    assign w_ed_neg = -w_ed;
    assign w_abs    = w_ed[N+1] ? w_ed_neg[N:0] : w_ed[N:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v   <= 1'b0;
            r_nz  <= 1'b0;
            r_ed  <= '0;
            r_abs <= '0;
        end else begin
            r_v <= w_accept;
            if (w_accept) begin
                r_ed  <= w_ed;
                r_abs <= w_abs;
                r_nz  <= |w_ed;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
            r_sum_ed    <= '0;
            r_sum_abs   <= '0;
            r_max_abs   <= '0;
        end else if (w_clear) begin
            r_err_count <= '0;
            r_sum_ed    <= '0;
            r_sum_abs   <= '0;
            r_max_abs   <= '0;
        end else if (r_v) begin
            r_sum_ed  <= r_sum_ed + {{WINDOW_LOG2{r_ed[N+1]}}, r_ed};
            r_sum_abs <= r_sum_abs + {{WINDOW_LOG2{1'b0}}, r_abs};
            if (r_nz) begin
                r_err_count <= r_err_count + c_cnt_one;
            end
            if (r_abs > r_max_abs) begin
                r_max_abs <= r_abs;
            end
        end
    end

    // FLUSH gives the stage-2 pipeline one cycle to absorb the last sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= c_st_accum;
                    end
                end
                c_st_accum: begin
                    if (w_accept) begin
                        r_cnt <= r_cnt + c_cnt_one;
                        if (r_cnt == c_last_idx) begin
                            r_state <= c_st_flush;
                        end
                    end
                end
                c_st_flush: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= c_st_done;
                end
                c_st_done: begin
                    r_done  <= 1'b0;
                    r_state <= c_st_idle;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err_count  = r_err_count;
    assign sum_ed     = r_sum_ed;
    assign sum_abs_ed = r_sum_abs;
    assign max_abs_ed = r_max_abs;

endmodule
`default_nettype wire

// File: tb/tb_approx_adder_error_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_approx_adder_error_monitor
// Brief    : Self-checking bench for approx_adder_error_monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_approx_adder_error_monitor;

    localparam int N  = 16;
    localparam int WL = 8;
    localparam int NS = 256;

    logic                   clk = 1'b0;
    logic                   rst;
    logic                   start;
    logic                   in_valid;
    logic [N-1:0]           a;
    logic [N-1:0]           b;
    logic [N:0]             approx_sum;
    logic                   busy;
    logic                   done;
    logic [WL:0]            err_count;
    logic signed [N+1+WL:0] sum_ed;
    logic [N+WL:0]          sum_abs_ed;
    logic [N:0]             max_abs_ed;

    approx_adder_error_monitor #(.N(N), .WINDOW_LOG2(WL)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_valid   (in_valid),
        .a          (a),
        .b          (b),
        .approx_sum (approx_sum),
        .busy       (busy),
        .done       (done),
        .err_count  (err_count),
        .sum_ed     (sum_ed),
        .sum_abs_ed (sum_abs_ed),
        .max_abs_ed (max_abs_ed)
    );

    always #5 clk = ~clk;

    typedef struct {
        string  name;
        int     kind;
        bit     gapped;
        bit     extras;
        longint err;
        longint sed;
        longint sabs;
        longint mx;
    } vec_t;

    typedef struct {
        string  name;
        longint err;
        longint sed;
        longint sabs;
        longint mx;
    } exp_t;

    exp_t         sb_q[$];
    int           n_cmp    = 0;
    int           n_bad    = 0;
    int           done_cnt = 0;
    int           done_cyc = -1;
    int           cyc      = 0;
    logic [N-1:0] sa  [NS];
    logic [N-1:0] sbv [NS];
    logic [N:0]   sap [NS];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endfunction

    // Results are popped from the scoreboard on every done pulse.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && done === 1'b1) begin
            done_cnt++;
            done_cyc = cyc;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, required no done");
            end else begin
                e = sb_q.pop_front();
                check({e.name, ".err_count"},  longint'(err_count),  e.err);
                check({e.name, ".sum_ed"},     longint'(sum_ed),     e.sed);
                check({e.name, ".sum_abs_ed"}, longint'(sum_abs_ed), e.sabs);
                check({e.name, ".max_abs_ed"}, longint'(max_abs_ed), e.mx);
                check({e.name, ".busy_in_done"}, longint'(busy), 64'sd0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // kind: 0 exact, 1 under-estimate by one, 2 extremes, 3 random small error
    task automatic gen(input int kind);
        for (int i = 0; i < NS; i++) begin
            int x;
            int y;
            int s;
            x = int'($urandom_range(0, 65535));
            y = int'($urandom_range(0, 65535));
            s = x + y;
            case (kind)
                1: begin
                    if (s == 0) begin
                        x = 1;
                        s = 1;
                    end
                    s = s - 1;
                end
                2: begin
                    if (i == 37) begin
                        x = 65535; y = 65535; s = 0;
                    end else if (i == 200) begin
                        x = 0; y = 0; s = 131071;
                    end
                end
                3: begin
                    s = s + int'($urandom_range(0, 6)) - 3;
                    if (s < 0) s = 0;
                    if (s > 131071) s = 131071;
                end
                default: ;
            endcase
            sa[i]  = x[N-1:0];
            sbv[i] = y[N-1:0];
            sap[i] = s[N:0];
        end
    endtask

    task automatic run_window(input exp_t e, input bit gapped, input bit extras);
        int last_cyc;
        int d0;
        last_cyc = -100;
        d0 = done_cnt;
        check({e.name, ".busy_before"}, longint'(busy), 64'sd0);
        start = 1'b1; in_valid = 1'b0;
        step();
        start = 1'b0;
        check({e.name, ".busy_after_start"}, longint'(busy), 64'sd1);
        sb_q.push_back(e);
        for (int i = 0; i < NS; i++) begin
            if (gapped && (i % 3 == 1)) begin
                in_valid = 1'b0; a = '1; b = '1; approx_sum = '0;
                start = (i == 100);
                step();
                start = 1'b0;
            end
            a = sa[i]; b = sbv[i]; approx_sum = sap[i]; in_valid = 1'b1;
            last_cyc = cyc;
            step();
        end
        for (int k = 1; k <= 4; k++) begin
            if (extras) begin
                in_valid = 1'b1; a = '1; b = '1; approx_sum = '0;
                start = (k == 2);
            end else begin
                in_valid = 1'b0;
            end
            step();
            start = 1'b0;
        end
        in_valid = 1'b0;
        repeat (2) step();
        check({e.name, ".done_pulses"},  longint'(done_cnt - d0), 64'sd1);
        check({e.name, ".done_latency"}, longint'(done_cyc - last_cyc), 64'sd2);
        check({e.name, ".busy_idle"},    longint'(busy), 64'sd0);
    endtask

    initial begin : timeout
        #1000000;
        $display("FAIL timeout: got no finish, required finish within 1 ms");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t   tbl[4];
        exp_t   e;
        longint me, ms, mab, mm, ed, ab;
        int     d0;

        tbl[0] = '{"exact",     0, 1'b0, 1'b0, 0,   0,  0,      0};
        tbl[1] = '{"under",     1, 1'b0, 1'b0, 256, 256, 256,   1};
        tbl[2] = '{"extremes",  2, 1'b0, 1'b0, 2,   -1, 262141, 131071};
        tbl[3] = '{"gapped",    1, 1'b1, 1'b1, 256, 256, 256,   1};

        rst = 1'b1; start = 1'b0; in_valid = 1'b0;
        a = '0; b = '0; approx_sum = '0;
        repeat (2) step();
        check("reset.busy",       longint'(busy),       64'sd0);
        check("reset.done",       longint'(done),       64'sd0);
        check("reset.err_count",  longint'(err_count),  64'sd0);
        check("reset.sum_ed",     longint'(sum_ed),     64'sd0);
        check("reset.sum_abs_ed", longint'(sum_abs_ed), 64'sd0);
        check("reset.max_abs_ed", longint'(max_abs_ed), 64'sd0);
        rst = 1'b0;
        step();

        for (int t = 0; t < 4; t++) begin
            gen(tbl[t].kind);
            e = '{tbl[t].name, tbl[t].err, tbl[t].sed, tbl[t].sabs, tbl[t].mx};
            run_window(e, tbl[t].gapped, tbl[t].extras);
        end

        // Random small errors, expectations from an integer model.
        gen(3);
        me = 0; ms = 0; mab = 0; mm = 0;
        for (int i = 0; i < NS; i++) begin
            ed = longint'(sa[i]) + longint'(sbv[i]) - longint'(sap[i]);
            ab = (ed < 0) ? -ed : ed;
            if (ed != 0) me++;
            ms  += ed;
            mab += ab;
            if (ab > mm) mm = ab;
        end
        e = '{"random", me, ms, mab, mm};
        run_window(e, 1'b1, 1'b0);

        // Asynchronous reset after 100 accepted samples.
        gen(1);
        d0 = done_cnt;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            a = sa[i]; b = sbv[i]; approx_sum = sap[i]; in_valid = 1'b1;
            step();
        end
        in_valid = 1'b0;
        check("midreset.partial_err_count", longint'(err_count), 64'sd99);
        #2 rst = 1'b1;
        #1;
        check("midreset.busy",       longint'(busy),       64'sd0);
        check("midreset.done",       longint'(done),       64'sd0);
        check("midreset.err_count",  longint'(err_count),  64'sd0);
        check("midreset.sum_ed",     longint'(sum_ed),     64'sd0);
        check("midreset.sum_abs_ed", longint'(sum_abs_ed), 64'sd0);
        check("midreset.max_abs_ed", longint'(max_abs_ed), 64'sd0);
        repeat (3) step();
        rst = 1'b0;
        repeat (5) step();
        check("midreset.no_done", longint'(done_cnt - d0), 64'sd0);

        gen(0);
        e = '{"after_reset", 0, 0, 0, 0};
        run_window(e, 1'b0, 1'b0);

        check("scoreboard_drained", longint'(sb_q.size()), 64'sd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
